// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the in-order pipeline
// writeback stream and the multiply/divide unit (MDU). MDU results wait in a
// small FIFO. Pipeline writes normally win. A starvation counter forces one MDU
// slot after the FIFO head has lost STARVE_MAX consecutive cycles. The winning
// write is registered once and feeds both the register file and the forwarding
// network.
module wb_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int MDU_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    // pipeline writeback stream
    input  logic                           p_valid_i,
    output logic                           p_ready_o,
    input  logic                           p_rd_wen_i,
    input  logic [4:0]                     p_rd_i,
    input  logic [XLEN-1:0]                p_data_i,
    // MDU result stream
    input  logic                           m_valid_i,
    output logic                           m_ready_o,
    input  logic [4:0]                     m_rd_i,
    input  logic [XLEN-1:0]                m_data_i,
    // register-file write port / forwarding path
    output logic                           wr_en_o,
    output logic [4:0]                     wr_rd_o,
    output logic [XLEN-1:0]                wr_data_o,
    output logic [$clog2(MDU_DEPTH+1)-1:0] m_count_o
);

    localparam int CW = $clog2(MDU_DEPTH + 1);
    localparam int PW = (MDU_DEPTH > 1) ? $clog2(MDU_DEPTH) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [CW-1:0] DEPTH_C  = CW'(MDU_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(MDU_DEPTH - 1);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

    typedef enum logic {
        PIPE_PRI  = 1'b0,
        MDU_FORCE = 1'b1
    } state_t;

    state_t state_reg, state_next;

    // MDU result storage; no reset needed because the pointers and count
    // define which entries are live.
    logic [4:0]      rd_mem   [MDU_DEPTH];
    logic [XLEN-1:0] data_mem [MDU_DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg,  count_next;
    logic [SW-1:0] starve_reg, starve_next;

    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;
    logic            fifo_nonempty;
    logic            need_p;
    logic            push;
    logic            pop;
    logic            grant;
    logic [4:0]      grant_rd;
    logic [XLEN-1:0] grant_data;

    logic            wr_en_reg;
    logic [4:0]      wr_rd_reg;
    logic [XLEN-1:0] wr_data_reg;

    // FIFO status and request decode; m_ready_o looks at occupancy only so
    // it never depends on a same-cycle pop.
    always_comb begin
        fifo_nonempty = (count_reg != '0);
        m_ready_o     = (count_reg < DEPTH_C);
        push          = m_valid_i && m_ready_o;
        need_p        = p_valid_i && p_rd_wen_i && (p_rd_i != 5'd0);
        head_rd       = rd_mem[rd_ptr_reg];
        head_data     = data_mem[rd_ptr_reg];
    end

    // Arbitration, starvation tracking and next-state selection.
    always_comb begin
        state_next  = state_reg;
        p_ready_o   = 1'b1;
        pop         = 1'b0;
        grant       = 1'b0;
        grant_rd    = p_rd_i;
        grant_data  = p_data_i;
        starve_next = starve_reg;

        case (state_reg)
            PIPE_PRI: begin
                if (need_p) begin
                    grant = 1'b1;
                end else if (fifo_nonempty) begin
                    pop        = 1'b1;
                    grant      = 1'b1;
                    grant_rd   = head_rd;
                    grant_data = head_data;
                end
            end
            MDU_FORCE: begin
                // Entered only with a non-empty FIFO, so the head is valid.
                p_ready_o  = 1'b0;
                pop        = 1'b1;
                grant      = 1'b1;
                grant_rd   = head_rd;
                grant_data = head_data;
                state_next = PIPE_PRI;
            end
            default: begin
                state_next = PIPE_PRI;
            end
        endcase

        // The counter measures how long the current head has been waiting:
        // the head only changes on a pop, which also clears the counter.
        if (pop) begin
            starve_next = '0;
        end else if (fifo_nonempty && (starve_reg != STARVE_C)) begin
            starve_next = starve_reg + 1'b1;
        end

        // Once the head has lost STARVE_MAX cycles the next cycle belongs to it.
        if ((state_reg == PIPE_PRI) && !pop && fifo_nonempty &&
            (starve_next == STARVE_C)) begin
            state_next = MDU_FORCE;
        end
    end

    // FIFO pointer and occupancy update with modulo-depth wrap.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;

        if (push) begin
            wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // FIFO entry write; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            rd_mem[wr_ptr_reg]   <= m_rd_i;
            data_mem[wr_ptr_reg] <= m_data_i;
        end
    end

    // Control state: FSM, pointers, occupancy and starvation counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= PIPE_PRI;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            starve_reg <= '0;
        end else begin
            state_reg  <= state_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            starve_reg <= starve_next;
        end
    end

    // Output register: an x0 target still consumes the grant but never writes,
    // and address/data hold their last values when nothing is written.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_en_reg   <= 1'b0;
            wr_rd_reg   <= '0;
            wr_data_reg <= '0;
        end else if (grant && (grant_rd != 5'd0)) begin
            wr_en_reg   <= 1'b1;
            wr_rd_reg   <= grant_rd;
            wr_data_reg <= grant_data;
        end else begin
            wr_en_reg   <= 1'b0;
        end
    end

    assign wr_en_o   = wr_en_reg;
    assign wr_rd_o   = wr_rd_reg;
    assign wr_data_o = wr_data_reg;
    assign m_count_o = count_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int XLEN       = 32;
    localparam int MDU_DEPTH  = 2;
    localparam int STARVE_MAX = 4;
    localparam int CW         = $clog2(MDU_DEPTH + 1);

    logic            clk_i;
    logic            rst_ni;
    logic            p_valid_i;
    logic            p_ready_o;
    logic            p_rd_wen_i;
    logic [4:0]      p_rd_i;
    logic [XLEN-1:0] p_data_i;
    logic            m_valid_i;
    logic            m_ready_o;
    logic [4:0]      m_rd_i;
    logic [XLEN-1:0] m_data_i;
    logic            wr_en_o;
    logic [4:0]      wr_rd_o;
    logic [XLEN-1:0] wr_data_o;
    logic [CW-1:0]   m_count_o;

    wb_port_arbiter #(
        .XLEN       (XLEN),
        .MDU_DEPTH  (MDU_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .p_valid_i  (p_valid_i),
        .p_ready_o  (p_ready_o),
        .p_rd_wen_i (p_rd_wen_i),
        .p_rd_i     (p_rd_i),
        .p_data_i   (p_data_i),
        .m_valid_i  (m_valid_i),
        .m_ready_o  (m_ready_o),
        .m_rd_i     (m_rd_i),
        .m_data_i   (m_data_i),
        .wr_en_o    (wr_en_o),
        .wr_rd_o    (wr_rd_o),
        .wr_data_o  (wr_data_o),
        .m_count_o  (m_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: queued MDU results as {rd, data}, how many
    // consecutive cycles the current head has been passed over, whether the
    // coming cycle is reserved for the head, and the expected output register.
    logic [36:0]     mq[$];
    int              head_lost = 0;
    bit              head_owed = 0;
    logic            exp_en    = 1'b0;
    logic [4:0]      exp_rd    = '0;
    logic [XLEN-1:0] exp_data  = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_wr();
        check("wr_en", 64'(wr_en_o), 64'(exp_en));
        check("wr_rd", 64'(wr_rd_o), 64'(exp_rd));
        check("wr_data", 64'(wr_data_o), 64'(exp_data));
        if (wr_en_o === 1'b1)
            $display("[%0t] write rd=%0d data=%08h queued=%0d", $time, wr_rd_o, wr_data_o, m_count_o);
    endtask

    task automatic drive_idle();
        p_valid_i  = 1'b0;
        p_rd_wen_i = 1'b0;
        p_rd_i     = '0;
        p_data_i   = '0;
        m_valid_i  = 1'b0;
        m_rd_i     = '0;
        m_data_i   = '0;
    endtask

    // One clock cycle: check last cycle's registered result, apply new inputs,
    // check the handshake outputs, then advance the model.
    task automatic step(input logic pv, input logic pwen, input logic [4:0] prd,
                        input logic [XLEN-1:0] pd, input logic mv,
                        input logic [4:0] mrd, input logic [XLEN-1:0] md);
        int          queued;
        bit          want_p;
        bit          mdu_wins;
        logic [36:0] head;
        @(negedge clk_i);
        check_wr();
        p_valid_i  = pv;
        p_rd_wen_i = pwen;
        p_rd_i     = prd;
        p_data_i   = pd;
        m_valid_i  = mv;
        m_rd_i     = mrd;
        m_data_i   = md;
        #1;
        queued = mq.size();
        check("p_ready", 64'(p_ready_o), 64'(!head_owed));
        check("m_ready", 64'(m_ready_o), 64'(queued < MDU_DEPTH));
        check("m_count", 64'(m_count_o), 64'(queued));

        want_p   = pv && pwen && (prd != 5'd0);
        mdu_wins = (queued > 0) && (head_owed || !want_p);

        if (mdu_wins) begin
            head      = mq.pop_front();
            exp_en    = (head[36:32] != 5'd0);
            if (exp_en) begin
                exp_rd   = head[36:32];
                exp_data = head[31:0];
            end
        end else if (want_p && !head_owed) begin
            exp_en   = 1'b1;
            exp_rd   = prd;
            exp_data = pd;
        end else begin
            exp_en = 1'b0;
        end

        if (mv && (queued < MDU_DEPTH))
            mq.push_back({mrd, md});

        // A head that lost this cycle accumulates waiting time; once it has
        // waited STARVE_MAX cycles the next cycle is handed to it.
        if (mdu_wins)
            head_lost = 0;
        else if (queued > 0 && head_lost < STARVE_MAX)
            head_lost++;
        head_owed = !mdu_wins && (queued > 0) && (head_lost == STARVE_MAX);
    endtask

    // Asynchronous reset in the middle of a cycle with traffic queued.
    task automatic reset_mid();
        @(negedge clk_i);
        check_wr();
        drive_idle();
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_wr_en", 64'(wr_en_o), 64'd0);
        check("rst_count", 64'(m_count_o), 64'd0);
        check("rst_p_ready", 64'(p_ready_o), 64'd1);
        check("rst_m_ready", 64'(m_ready_o), 64'd1);
        mq.delete();
        head_lost = 0;
        head_owed = 0;
        exp_en    = 1'b0;
        exp_rd    = '0;
        exp_data  = '0;
        @(negedge clk_i);
        check("rst_hold_rd", 64'(wr_rd_o), 64'd0);
        check("rst_hold_data", 64'(wr_data_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic random_phase(input int cycles, input int p_pct, input int m_pct);
        logic [4:0] prd;
        for (int i = 0; i < cycles; i++) begin
            prd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step(($urandom_range(0, 99) < p_pct), ($urandom_range(0, 9) != 0), prd, $urandom(),
                 ($urandom_range(0, 99) < m_pct), 5'($urandom_range(0, 31)), $urandom());
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk_i);
        #1;
        check("reset_wr_en", 64'(wr_en_o), 64'd0);
        check("reset_wr_rd", 64'(wr_rd_o), 64'd0);
        check("reset_wr_data", 64'(wr_data_o), 64'd0);
        check("reset_count", 64'(m_count_o), 64'd0);
        check("reset_p_ready", 64'(p_ready_o), 64'd1);
        check("reset_m_ready", 64'(m_ready_o), 64'd1);
        rst_ni = 1'b1;

        // Pipeline only, then an x0 target.
        step(1, 1, 5'd5, 32'h1234, 0, 5'd0, 0);
        step(1, 1, 5'd0, 32'h5555, 0, 5'd0, 0);
        step(0, 0, 5'd0, 0, 0, 5'd0, 0);

        // MDU result with the pipeline idle, then a non-writing pipeline op
        // in the MDU grant cycle.
        step(0, 0, 5'd0, 0, 1, 5'd7, 32'hAA);
        step(1, 0, 5'd3, 32'h9, 0, 5'd0, 0);
        step(0, 0, 5'd0, 0, 0, 5'd0, 0);
        step(0, 0, 5'd0, 0, 0, 5'd0, 0);

        // Starvation: one MDU entry under continuous pipeline writes.
        step(1, 1, 5'd9, 32'h100, 1, 5'd12, 32'hBEEF);
        for (int i = 0; i < 8; i++)
            step(1, 1, 5'(10 + i), 32'(32'h200 + i), 0, 5'd0, 0);

        // Full FIFO with MDU valid held and the pipeline saturating.
        for (int i = 0; i < 14; i++)
            step(1, 1, 5'(1 + i), 32'(32'h300 + i), 1, 5'(16 + i), 32'(32'h400 + i));
        for (int i = 0; i < 6; i++)
            step(0, 0, 5'd0, 0, 0, 5'd0, 0);

        // Reset with two entries queued; no stale write afterwards.
        step(1, 1, 5'd4, 32'h500, 1, 5'd20, 32'h600);
        step(1, 1, 5'd4, 32'h501, 1, 5'd21, 32'h601);
        reset_mid();
        step(0, 0, 5'd0, 0, 0, 5'd0, 0);
        step(0, 0, 5'd0, 0, 0, 5'd0, 0);

        // Ten MDU results with the pipeline idle exercise pointer wrap.
        for (int i = 0; i < 10; i++)
            step(0, 0, 5'd0, 0, 1, 5'(1 + i), 32'(32'h700 + i));
        for (int i = 0; i < 4; i++)
            step(0, 0, 5'd0, 0, 0, 5'd0, 0);

        // Randomized traffic: pipeline heavy, balanced, MDU heavy.
        random_phase(200, 95, 60);
        random_phase(200, 50, 50);
        random_phase(100, 20, 80);
        for (int i = 0; i < 8; i++)
            step(0, 0, 5'd0, 0, 0, 5'd0, 0);
        @(negedge clk_i);
        check_wr();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
